taylor_mac: RTL and testbench

Streaming FP32 polynomial evaluator for the non-linear approximation engine (sigmoid, tanh, GeLU Taylor series). A coefficient store is loaded once, highest order first. Input samples x are queued in a signal FIFO, and each sample is evaluated by Horner's rule (acc = acc·x + c[k]) on one shared multiply-add datapath. The block sits between the sample/coefficient producers and the activation output.

---
 rtl/taylor_pkg.sv | 29 ++
 rtl/fp32_muladd.sv | 69 ++++++
 rtl/taylor_mac.sv | 121 ++++++++++++
 tb/tb_taylor_mac.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taylor_pkg.sv
// Shared FSM state type, binary32 field constants and the round/pack helper
// used by the Horner evaluator.
package taylor_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, STEP} state_e;

    localparam int         FP_EXP_W   = 8;
    localparam int         FP_MAN_W   = 23;
    localparam int         FP_BIAS    = 127;
    localparam logic [7:0] FP_EXP_MAX = 8'hFF;

    // m carries the hidden bit; e is the biased exponent before rounding.
    // Anything below the normal range flushes to signed zero.
    function automatic logic [31:0] fp_round(input logic s, input int e, input logic [23:0] m,
                                             input logic g, input logic st);
        logic [24:0] r;
        int          ee;
        if (e < 1) return {s, 31'b0};
        r  = {1'b0, m} + {24'b0, g & (st | m[0])};
        ee = e;
        if (r[24]) begin
            ee = e + 1;
            r  = r >> 1;
        end
        if (ee >= 255) return {s, FP_EXP_MAX, 23'b0};
        return {s, ee[7:0], r[22:0]};
    endfunction

endpackage

// File: rtl/fp32_muladd.sv
// Combinational binary32 o_y = i_a*i_b + i_c with the product and the sum each
// rounded to nearest-even; subnormals flush to signed zero, overflow gives Inf.
module fp32_muladd
    import taylor_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    output logic [31:0] o_y
);
    logic [FP_EXP_W-1:0] w_ea, w_eb;
    logic [47:0]         w_prod, w_pnorm;
    logic [31:0]         w_p, w_big, w_sml;
    logic [50:0]         w_mb, w_ms, w_al, w_sum, w_norm;
    logic                w_psign;
    int                  w_pexp, w_d, w_pos;

    assign w_ea    = i_a[30:FP_MAN_W];
    assign w_eb    = i_b[30:FP_MAN_W];
    assign w_psign = i_a[31] ^ i_b[31];

    always_comb begin
        w_prod  = {24'b0, 1'b1, i_a[FP_MAN_W-1:0]} * {24'b0, 1'b1, i_b[FP_MAN_W-1:0]};
        w_pnorm = w_prod[47] ? w_prod : (w_prod << 1);
        w_pexp  = int'(w_ea) + int'(w_eb) - FP_BIAS + int'(w_prod[47]);
        if (w_ea == FP_EXP_MAX || w_eb == FP_EXP_MAX)
            w_p = {w_psign, FP_EXP_MAX, 23'b0};
        else if (w_ea == '0 || w_eb == '0)
            w_p = {w_psign, 31'b0};
        else
            w_p = fp_round(w_psign, w_pexp, w_pnorm[47:24], w_pnorm[23], |w_pnorm[22:0]);
    end

    // Hidden bit sits at 49 with 26 guard bits; a far-shifted addend only
    // contributes a sticky bit, which is enough for correct rounding.
    always_comb begin
        w_big = (i_c[30:0] > w_p[30:0]) ? i_c : w_p;
        w_sml = (i_c[30:0] > w_p[30:0]) ? w_p : i_c;
        w_d   = int'(w_big[30:23]) - int'(w_sml[30:23]);
        w_mb  = {2'b01, w_big[22:0], 26'b0};
        w_ms  = {2'b01, w_sml[22:0], 26'b0};
        if (w_d > 50)
            w_al = 51'd1;
        else
            w_al = (w_ms >> w_d) | {50'b0, |(w_ms & ~({51{1'b1}} << w_d))};
        w_sum = (w_big[31] ^ w_sml[31]) ? (w_mb - w_al) : (w_mb + w_al);
        w_pos = 0;
        for (int i = 0; i < 51; i++)
            if (w_sum[i]) w_pos = i;
        w_norm = w_sum << (50 - w_pos);

        if (w_p[30:23] == FP_EXP_MAX)
            o_y = w_p;
        else if (i_c[30:23] == FP_EXP_MAX)
            o_y = i_c;
        else if (w_p[30:23] == '0 && i_c[30:23] == '0)
            o_y = {w_p[31] & i_c[31], 31'b0};
        else if (w_p[30:23] == '0)
            o_y = i_c;
        else if (i_c[30:23] == '0)
            o_y = w_p;
        else if (w_sum == '0)
            o_y = 32'b0;
        else
            o_y = fp_round(w_big[31], int'(w_big[30:23]) + w_pos - 49,
                           w_norm[50:27], w_norm[26], |w_norm[25:0]);
    end

endmodule

// File: rtl/taylor_mac.sv
// Streaming FP32 Horner evaluator: sample FIFO, write-once coefficient store,
// and an IDLE/LOAD/STEP engine sharing a single multiply-add.
module taylor_mac
    import taylor_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] signal_fifo,
    input  logic                  wr_en_signal,
    input  logic                  last_signal,
    output logic                  idle_signal,
    input  logic [DATA_WIDTH-1:0] coeff_fifo,
    input  logic                  wr_en_coeff,
    input  logic                  last_coeff,
    output logic                  idle_coeff,
    input  logic [ADDR_LINES-1:0] taylor_length,
    output logic                  full_mul,
    output logic                  empty_mul,
    output logic                  full_adder,
    output logic                  empty_adder,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int DEPTH = 1 << ADDR_LINES;

    logic [DATA_WIDTH-1:0] r_sig_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] r_coef_mem [DEPTH];
    logic [ADDR_LINES:0]   r_sig_wp, r_sig_rp, r_coef_wp;
    logic                  r_locked;
    state_e                r_state, w_next;
    logic [ADDR_LINES-1:0] r_k, r_len;
    logic [DATA_WIDTH-1:0] r_x, r_acc, r_result, w_fma;
    logic                  w_push, w_pop, w_cwr, w_step, w_last_step, w_res_we;
    logic                  w_unused;

    // End-of-stream marker carries no control meaning for the engine.
    assign w_unused = last_signal;

    assign full_mul    = (r_sig_wp[ADDR_LINES] != r_sig_rp[ADDR_LINES]) &&
                         (r_sig_wp[ADDR_LINES-1:0] == r_sig_rp[ADDR_LINES-1:0]);
    assign empty_mul   = (r_sig_wp == r_sig_rp);
    assign idle_signal = !full_mul;
    assign w_push      = wr_en_signal && !full_mul;
    assign full_adder  = r_coef_wp[ADDR_LINES];
    assign empty_adder = (r_coef_wp == '0);
    assign idle_coeff  = !r_locked && !full_adder;
    assign w_cwr       = wr_en_coeff && idle_coeff;
    assign result      = r_result;

    always_ff @(posedge clk_i) begin
        if (w_push) r_sig_mem[r_sig_wp[ADDR_LINES-1:0]]   <= signal_fifo;
        if (w_cwr)  r_coef_mem[r_coef_wp[ADDR_LINES-1:0]] <= coeff_fifo;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sig_wp  <= '0;
            r_sig_rp  <= '0;
            r_coef_wp <= '0;
            r_locked  <= 1'b0;
        end else begin
            if (w_push)     r_sig_wp  <= r_sig_wp + 1'b1;
            if (w_pop)      r_sig_rp  <= r_sig_rp + 1'b1;
            if (w_cwr)      r_coef_wp <= r_coef_wp + 1'b1;
            if (last_coeff) r_locked  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_locked && !empty_mul) w_next = LOAD;
            LOAD:    w_next = (taylor_length == '0) ? IDLE : STEP;
            STEP:    if (w_last_step) w_next = empty_mul ? IDLE : LOAD;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_pop       = (r_state == LOAD);
        w_step      = (r_state == STEP);
        w_last_step = w_step && (r_k == r_len);
        w_res_we    = (w_pop && taylor_length == '0) || w_last_step;
    end

    fp32_muladd u_fma (
        .i_a (r_acc),
        .i_b (r_x),
        .i_c (r_coef_mem[r_k]),
        .o_y (w_fma)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x      <= '0;
            r_acc    <= '0;
            r_k      <= '0;
            r_len    <= '0;
            r_result <= '0;
        end else begin
            if (w_pop) begin
                r_x   <= r_sig_mem[r_sig_rp[ADDR_LINES-1:0]];
                r_acc <= r_coef_mem[0];
                r_k   <= {{(ADDR_LINES-1){1'b0}}, 1'b1};
                r_len <= taylor_length;
            end else if (w_step) begin
                r_acc <= w_fma;
                r_k   <= r_k + 1'b1;
            end
            if (w_res_we) r_result <= w_pop ? r_coef_mem[0] : w_fma;
        end
    end

endmodule

// File: tb/tb_taylor_mac.sv
// Randomized scoreboard bench for taylor_mac against a real-arithmetic
// reference model of the FP32 Horner evaluation.
module tb_taylor_mac;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   sig = '0, coef = '0;
    logic          wr_sig = 1'b0, last_sig = 1'b0, wr_coef = 1'b0, last_coef = 1'b0;
    logic [AW-1:0] tlen = '0;
    logic          idle_signal, idle_coeff, full_mul, empty_mul, full_adder, empty_adder;
    logic [31:0]   result;

    taylor_mac #(.DATA_WIDTH(32), .ADDR_LINES(AW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .signal_fifo  (sig),
        .wr_en_signal (wr_sig),
        .last_signal  (last_sig),
        .idle_signal  (idle_signal),
        .coeff_fifo   (coef),
        .wr_en_coeff  (wr_coef),
        .last_coeff   (last_coef),
        .idle_coeff   (idle_coeff),
        .taylor_length(tlen),
        .full_mul     (full_mul),
        .empty_mul    (empty_mul),
        .full_adder   (full_adder),
        .empty_adder  (empty_adder),
        .result       (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0, n_bad = 0, n_res = 0;
    logic [31:0] exp_q[$];
    int          res_cyc[$];
    logic [31:0] cref[32];
    int          lref = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference arithmetic: binary32 <-> real, with flush-to-zero and RNE.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h00)      d = {f[31], 63'b0};
        else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, 52'b0};
        else                        d = {f[31], 11'({3'b0, f[30:23]} + 11'd896), f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic [63:0] d;
        int          e;
        logic [24:0] m;
        d = $realtobits(v);
        if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, 23'b0};
        if (d[62:0] == '0) return {d[63], 31'b0};
        e = int'(d[62:52]) - 1023 + 127;
        if (e < 1) return {d[63], 31'b0};
        m = {2'b01, d[51:29]};
        if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e > 254) return {d[63], 8'hFF, 23'b0};
        return {d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] ref_fma(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        return r2f(f2r(r2f(f2r(a) * f2r(b))) + f2r(c));
    endfunction

    function automatic logic [31:0] horner(input logic [31:0] x);
        logic [31:0] acc;
        acc = cref[0];
        for (int k = 1; k <= lref; k++) acc = ref_fma(acc, x, cref[k]);
        return acc;
    endfunction

    function automatic logic [31:0] rand_fp(input int lo, input int hi);
        logic [7:0] e;
        e = 8'($urandom_range(hi, lo));
        return {1'($urandom_range(1, 0)), e, 23'($urandom)};
    endfunction

    // Monitor: a result-register write seen before an edge is checked after it.
    initial forever begin
        @(negedge clk);
        if (dut.w_res_we && !rst) begin
            @(posedge clk);
            #1;
            n_res++;
            res_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_result: got %h expected no result", result);
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick(2);
        rst = 1'b0;
    endtask

    task automatic load_coeffs(input int n, input bit lock);
        for (int i = 0; i < n; i++) begin
            coef    = cref[i];
            wr_coef = 1'b1;
            tick();
        end
        wr_coef = 1'b0;
        if (lock) begin
            last_coef = 1'b1;
            tick();
            last_coef = 1'b0;
        end
    endtask

    task automatic push(input logic [31:0] x, input bit has_exp, input logic [31:0] expv);
        sig    = x;
        wr_sig = 1'b1;
        if (has_exp) exp_q.push_back(expv);
        tick();
        wr_sig = 1'b0;
    endtask

    task automatic wait_res(input int target, input int budget, input string name);
        int t;
        t = 0;
        while (n_res < target && t < budget) begin
            tick();
            t++;
        end
        n_cmp++;
        if (n_res < target) begin
            n_bad++;
            $display("FAIL %s: got %0d results expected %0d", name, n_res, target);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p1, base;
        logic [31:0] x;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        check("rst_result", result, 32'h0);
        check("rst_empty_mul", 32'(empty_mul), 32'd1);
        check("rst_empty_adder", 32'(empty_adder), 32'd1);
        check("rst_full_mul", 32'(full_mul), 32'd0);
        check("rst_full_adder", 32'(full_adder), 32'd0);
        check("rst_idle_signal", 32'(idle_signal), 32'd1);
        check("rst_idle_coeff", 32'(idle_coeff), 32'd1);

        // Horner with x = 1.0, then -1.0 and 2.0 back-to-back
        cref[0] = 32'h40000000; cref[1] = 32'h40400000; cref[2] = 32'h3F800000;
        lref = 2;
        tlen = 5'd2;
        load_coeffs(3, 1'b1);
        check("locked_empty_adder", 32'(empty_adder), 32'd0);
        check("locked_idle_coeff", 32'(idle_coeff), 32'd0);
        push(32'h3F800000, 1'b1, 32'h40C00000);
        p0 = cyc;
        wait_res(1, 20, "x_one");
        check("latency_push_to_result", 32'(res_cyc[0] - p0), 32'd4);
        push(32'hBF800000, 1'b1, 32'h00000000);
        p1 = cyc;
        push(32'h40000000, 1'b1, 32'h41700000);
        wait_res(3, 30, "two_samples");
        check("latency_first", 32'(res_cyc[1] - p1), 32'd4);
        check("back_to_back_spacing", 32'(res_cyc[2] - res_cyc[1]), 32'd3);
        tick(4);
        check("result_hold", result, 32'h41700000);
        check("drained_empty_mul", 32'(empty_mul), 32'd1);

        // Constant term with the 31-word set; fill the store to check full_adder
        do_reset();
        check("empty_adder_after_reset", 32'(empty_adder), 32'd1);
        cref[0] = 32'h189C9963;
        for (int i = 1; i < 32; i++) cref[i] = rand_fp(100, 126);
        cref[30] = 32'h3F800000;
        lref = 30;
        tlen = 5'd30;
        load_coeffs(32, 1'b0);
        check("store_full_adder", 32'(full_adder), 32'd1);
        check("store_full_idle_coeff", 32'(idle_coeff), 32'd0);
        last_coef = 1'b1;
        tick();
        last_coef = 1'b0;
        base = n_res;
        push(32'h00000000, 1'b1, 32'h3F800000);
        push(32'h80000001, 1'b1, 32'h3F800000);
        push(32'h3F000000, 1'b1, horner(32'h3F000000));
        wait_res(base + 3, 200, "constant_term");

        // Random coefficient sets and samples, L = 0 first
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            lref = (ph == 0) ? 0 : int'($urandom_range(6, 1));
            tlen = 5'(lref);
            for (int i = 0; i <= lref; i++) cref[i] = rand_fp(110, 135);
            load_coeffs(lref + 1, 1'b1);
            base = n_res;
            for (int s = 0; s < 16; s++) begin
                x = ($urandom_range(7, 0) == 0) ? {1'($urandom_range(1, 0)), 8'h00, 23'($urandom)}
                                                : rand_fp(118, 130);
                push(x, 1'b1, horner(x));
                tick($urandom_range(3, 0));
            end
            wait_res(base + 16, 400, "random_phase");
        end

        // FIFO full while unlocked; 33rd push dropped
        do_reset();
        cref[0] = 32'h40000000; cref[1] = 32'h40400000; cref[2] = 32'h3F800000;
        lref = 2;
        tlen = 5'd2;
        for (int s = 0; s < 33; s++) begin
            x = rand_fp(120, 130);
            push(x, s < 32, horner(x));
            if (s == 30) check("full_mul_at_31", 32'(full_mul), 32'd0);
            if (s == 31) begin
                check("full_mul_at_32", 32'(full_mul), 32'd1);
                check("idle_signal_at_32", 32'(idle_signal), 32'd0);
            end
        end
        check("full_mul_after_drop", 32'(full_mul), 32'd1);
        base = n_res;
        load_coeffs(3, 1'b1);
        wait_res(base + 32, 200, "fifo_drain");
        tick(10);
        check("fifo_result_count", 32'(n_res - base), 32'd32);
        check("fifo_empty_after", 32'(empty_mul), 32'd1);

        // Writes after lock are ignored
        coef    = 32'h42000000;
        wr_coef = 1'b1;
        tick(3);
        wr_coef = 1'b0;
        check("post_lock_idle_coeff", 32'(idle_coeff), 32'd0);
        x = rand_fp(120, 128);
        base = n_res;
        push(x, 1'b1, horner(x));
        wait_res(base + 1, 20, "post_lock_sample");

        // Reset during the first STEP aborts the sample and drops the queue
        base = n_res;
        push(rand_fp(120, 128), 1'b0, 32'h0);
        push(rand_fp(120, 128), 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset_result", result, 32'h0);
        check("mid_reset_idle_coeff", 32'(idle_coeff), 32'd1);
        check("mid_reset_empty_mul", 32'(empty_mul), 32'd1);
        tick(15);
        check("no_result_after_reset", 32'(n_res - base), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
